// File: rtl/axis_dac_spi_pkg.sv
// Shared constants and types for the AXIS-to-SPI DAC writer.
package axis_dac_spi_pkg;

  localparam int FRAME_WIDTH = 24;
  localparam int FRAMES      = 4;
  localparam int WORD_WIDTH  = FRAME_WIDTH * FRAMES;
  localparam int IDX_W       = $clog2(FRAMES + 1);

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SHIFT,
    GAP
  } state_e;

endpackage

// File: rtl/axis_dac_spi_writer_if.sv
// AXI-Stream command-word channel from the sample-to-command packer.
interface axis_dac_spi_writer_if;
  import axis_dac_spi_pkg::*;

  logic [WORD_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_dac_spi_writer_shifter.sv
// Serialises one frame MSB-first: sclk divider, bit counter, shift register.
// sdo is the shift register MSB, so it only moves when the register moves.
module spi_frame_shifter #(
  parameter int FRAME_WIDTH = 24,
  parameter int SCLK_DIV    = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start_i,
  input  logic [FRAME_WIDTH-1:0] frame_i,
  output logic                   done_o,
  output logic                   sclk_o,
  output logic                   sync_n_o,
  output logic                   sdo_o
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_WIDTH);

  logic                   active_q;
  logic                   sclk_q;
  logic                   sync_n_q;
  logic [DIV_W-1:0]       div_q;
  logic [BIT_W-1:0]       bit_q;
  logic [FRAME_WIDTH-1:0] shreg_q;

  logic wrap;
  logic last_bit;

  assign wrap     = (div_q == DIV_W'(SCLK_DIV - 1));
  assign last_bit = (bit_q == BIT_W'(FRAME_WIDTH - 1));
  // The frame ends on the falling edge of its last bit.
  assign done_o   = active_q & wrap & sclk_q & last_bit;

  assign sclk_o   = sclk_q;
  assign sync_n_o = sync_n_q;
  assign sdo_o    = shreg_q[FRAME_WIDTH-1];

  // Divider/bit counter: sclk toggles on each divider wrap; data moves on falling edges.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      sync_n_q <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      sclk_q   <= 1'b0;
      sync_n_q <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= frame_i;
    end else if (active_q) begin
      div_q <= wrap ? '0 : div_q + 1'b1;
      if (wrap) begin
        if (!sclk_q) begin
          sclk_q <= 1'b1;
        end else if (last_bit) begin
          active_q <= 1'b0;
          sclk_q   <= 1'b0;
          sync_n_q <= 1'b1;
          shreg_q  <= '0;
        end else begin
          sclk_q  <= 1'b0;
          bit_q   <= bit_q + 1'b1;
          shreg_q <= shreg_q << 1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_dac_spi_writer.sv
// Takes 96-bit DAC command words from AXIS into a one-deep holding register
// and sends each of their 24-bit frames to a 3-wire SPI DAC.
module axis_dac_spi_writer
  import axis_dac_spi_pkg::*;
#(
  parameter int SCLK_DIV  = 4,
  parameter int CS_GAP    = 2,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_dac_spi_writer_if.slave  s_axis,
  output logic                  spi_sclk,
  output logic                  spi_sync_n,
  output logic                  spi_sdo,
  output logic                  sts_busy,
  output logic [15:0]           sts_drop_cntr
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [GAP_W-1:0]      gap_q, gap_d;

  logic [WORD_WIDTH-1:0] hold_q;
  logic                  hold_full_q;
  logic [15:0]           drop_q;

  logic drain;
  logic start;
  logic frame_done;

  // tready reflects the holding register only, and is held low during reset.
  assign s_axis.tready = ~hold_full_q & ~areset;
  assign sts_busy      = (state_q != IDLE) | hold_full_q;
  assign sts_drop_cntr = drop_q;

  // Holding register: filled on handshake, emptied when IDLE copies it out.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hold_full_q <= 1'b0;
      hold_q      <= '0;
    end else if (s_axis.tvalid && s_axis.tready) begin
      hold_full_q <= 1'b1;
      hold_q      <= s_axis.tdata;
    end else if (drain) begin
      hold_full_q <= 1'b0;
    end
  end

  // Drop counter: a word offered while tready is low is lost; count it, saturating.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      drop_q <= '0;
    end else if (s_axis.tvalid && !s_axis.tready && drop_q != DROP_MAX) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      gap_q   <= gap_d;
    end
  end

  // FSM next state: the shift word moves down one frame whenever frame_idx advances,
  // so the current frame is always its low 24 bits. sync_n stays high for the GAP
  // cycles plus the SELECT cycle, hence GAP lasts CS_GAP-1 cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    gap_d   = gap_q;
    drain   = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          word_d  = hold_q;
          idx_d   = '0;
          drain   = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (idx_q == IDX_W'(FRAMES)) begin
          state_d = IDLE;
        end else if (SKIP_ZERO && word_q[FRAME_WIDTH-1:0] == '0) begin
          idx_d  = idx_q + 1'b1;
          word_d = word_q >> FRAME_WIDTH;
        end else begin
          start   = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (frame_done) begin
          idx_d   = idx_q + 1'b1;
          word_d  = word_q >> FRAME_WIDTH;
          gap_d   = '0;
          state_d = (CS_GAP > 1) ? GAP : SELECT;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(CS_GAP - 2)) begin
          state_d = SELECT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  spi_frame_shifter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .SCLK_DIV    (SCLK_DIV)
  ) u_shifter (
    .aclk     (aclk),
    .areset   (areset),
    .start_i  (start),
    .frame_i  (word_q[FRAME_WIDTH-1:0]),
    .done_o   (frame_done),
    .sclk_o   (spi_sclk),
    .sync_n_o (spi_sync_n),
    .sdo_o    (spi_sdo)
  );

endmodule

// File: tb/tb_axis_dac_spi_writer.sv
// Bench for axis_dac_spi_writer: three instances (default, SKIP_ZERO=0,
// SCLK_DIV=1/CS_GAP=1). A pin-level monitor rebuilds frames from the SPI bus;
// a frame-list model built from each sent word gives the expected frames.
module tb_axis_dac_spi_writer;

  localparam int FW = 24;
  localparam int NF = 4;

  typedef struct {
    int          dut;
    logic [23:0] data;
    int          rises;
    int          low_len;
    int          gap;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst     [3];
  logic [95:0] tdata   [3];
  logic        tvalid  [3];
  logic        tready  [3];
  logic        sclk    [3];
  logic        sync_n  [3];
  logic        sdo     [3];
  logic        busy    [3];
  logic [15:0] drop    [3];

  int tests = 0;
  int fails = 0;
  int sdo_bad = 0;

  frame_t mon_q[$];
  frame_t exp_q[$];

  always #5 clk = ~clk;

  axis_dac_spi_writer_if if0 ();
  axis_dac_spi_writer_if if1 ();
  axis_dac_spi_writer_if if2 ();

  assign if0.tdata = tdata[0];  assign if0.tvalid = tvalid[0];  assign tready[0] = if0.tready;
  assign if1.tdata = tdata[1];  assign if1.tvalid = tvalid[1];  assign tready[1] = if1.tready;
  assign if2.tdata = tdata[2];  assign if2.tvalid = tvalid[2];  assign tready[2] = if2.tready;

  axis_dac_spi_writer #(.SCLK_DIV(4), .CS_GAP(2), .SKIP_ZERO(1'b1)) dut0 (
    .aclk(clk), .areset(rst[0]), .s_axis(if0.slave), .spi_sclk(sclk[0]),
    .spi_sync_n(sync_n[0]), .spi_sdo(sdo[0]), .sts_busy(busy[0]), .sts_drop_cntr(drop[0]));

  axis_dac_spi_writer #(.SCLK_DIV(4), .CS_GAP(2), .SKIP_ZERO(1'b0)) dut1 (
    .aclk(clk), .areset(rst[1]), .s_axis(if1.slave), .spi_sclk(sclk[1]),
    .spi_sync_n(sync_n[1]), .spi_sdo(sdo[1]), .sts_busy(busy[1]), .sts_drop_cntr(drop[1]));

  axis_dac_spi_writer #(.SCLK_DIV(1), .CS_GAP(1), .SKIP_ZERO(1'b1)) dut2 (
    .aclk(clk), .areset(rst[2]), .s_axis(if2.slave), .spi_sclk(sclk[2]),
    .spi_sync_n(sync_n[2]), .spi_sdo(sdo[2]), .sts_busy(busy[2]), .sts_drop_cntr(drop[2]));

  function automatic int div_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic int gap_of(input int d);
    return (d == 2) ? 1 : 2;
  endfunction

  function automatic bit skip_of(input int d);
    return (d != 1);
  endfunction

  // Pin-level monitor, sampled on the falling aclk edge.
  logic        prev_sclk [3] = '{1'b0, 1'b0, 1'b0};
  logic        prev_sync [3] = '{1'b1, 1'b1, 1'b1};
  logic        prev_sdo  [3] = '{1'b0, 1'b0, 1'b0};
  bit          in_frame  [3] = '{0, 0, 0};
  logic [23:0] acc       [3];
  int          rises     [3];
  int          low_len   [3];
  int          high_cnt  [3] = '{0, 0, 0};
  int          gap_fall  [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        in_frame[d] = 0;
        high_cnt[d] = 0;
      end else begin
        if (prev_sync[d] && !sync_n[d]) begin
          in_frame[d] = 1;
          acc[d]      = '0;
          rises[d]    = 0;
          low_len[d]  = 0;
          gap_fall[d] = high_cnt[d];
        end
        if (in_frame[d]) begin
          if (!sync_n[d]) begin
            low_len[d]++;
            if (!prev_sclk[d] && sclk[d]) begin
              acc[d] = {acc[d][22:0], sdo[d]};
              rises[d]++;
            end
            if (!prev_sync[d] && sdo[d] !== prev_sdo[d] && !(prev_sclk[d] && !sclk[d]))
              sdo_bad++;
          end else begin
            mon_q.push_back('{d, acc[d], rises[d], low_len[d], gap_fall[d]});
            in_frame[d] = 0;
          end
        end
        high_cnt[d] = sync_n[d] ? high_cnt[d] + 1 : 0;
      end
      prev_sclk[d] = sclk[d];
      prev_sync[d] = sync_n[d];
      prev_sdo[d]  = sdo[d];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frames of a word: skipped zero frames widen the following gap by one cycle each.
  task automatic expect_word(input int d, input logic [95:0] w);
    int          skipped = 0;
    bit          first   = 1;
    logic [23:0] f;
    for (int i = 0; i < NF; i++) begin
      f = w[i*FW +: FW];
      if (skip_of(d) && f == 24'h0) begin
        skipped++;
      end else begin
        exp_q.push_back('{d, f, FW, 2 * div_of(d) * FW, first ? -1 : gap_of(d) + skipped});
        first   = 0;
        skipped = 0;
      end
    end
  endtask

  // Waits for tready, then offers the word for exactly one cycle (a clean handshake).
  task automatic send(input int d, input logic [95:0] w);
    int n = 0;
    @(negedge clk);
    while (!tready[d] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("send_tready", 32'(tready[d]), 32'd1);
    tdata[d]  = w;
    tvalid[d] = 1'b1;
    @(negedge clk);
    tvalid[d] = 1'b0;
    expect_word(d, w);
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[d] || !sync_n[d]) && n < 20000);
    check("idle_reached", 32'(busy[d]), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    int n;
    check({tag, "_frame_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_dut"},     32'(mon_q[i].dut),     32'(exp_q[i].dut));
      check({tag, "_data"},    32'(mon_q[i].data),    32'(exp_q[i].data));
      check({tag, "_sclk_rises"}, 32'(mon_q[i].rises), 32'(exp_q[i].rises));
      check({tag, "_sync_low"}, 32'(mon_q[i].low_len), 32'(exp_q[i].low_len));
      if (exp_q[i].gap >= 0)
        check({tag, "_sync_gap"}, 32'(mon_q[i].gap), 32'(exp_q[i].gap));
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  function automatic logic [95:0] rand_word();
    logic [95:0] w;
    for (int i = 0; i < NF; i++)
      w[i*FW +: FW] = ($urandom_range(3) == 0) ? 24'h0 : 24'($urandom);
    return w;
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0] w1;
    w1 = {24'h0, 24'h250000, 8'h14, 16'hBEEF, 8'h11, 16'h1234};
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; tvalid[d] = 1'b0; tdata[d] = '0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_sclk",   32'(sclk[0]),   32'd0);
    check("rst_sync_n", 32'(sync_n[0]), 32'd1);
    check("rst_sdo",    32'(sdo[0]),    32'd0);
    check("rst_tready", 32'(tready[0]), 32'd0);
    check("rst_busy",   32'(busy[0]),   32'd0);
    check("rst_drop",   32'(drop[0]),   32'd0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 32'(tready[0]), 32'd1);

    // Directed word on defaults: three frames, latency two cycles to sync_n fall.
    send(0, w1);
    check("t1_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    check("t1_sync_k1", 32'(sync_n[0]), 32'd1);
    @(negedge clk);
    check("t1_sync_k2", 32'(sync_n[0]), 32'd0);
    wait_idle(0);
    compare_all("t1");

    // Back-to-back words, then one dropped word.
    send(0, rand_word());
    send(0, rand_word());
    @(negedge clk);
    check("t2_tready_full", 32'(tready[0]), 32'd0);
    tdata[0]  = {4{24'hDEAD01}};
    tvalid[0] = 1'b1;
    @(negedge clk);
    tvalid[0] = 1'b0;
    check("t2_drop", 32'(drop[0]), 32'd1);
    wait_idle(0);
    compare_all("t2");
    check("t2_drop_hold", 32'(drop[0]), 32'd1);

    // All-zero word: no SPI activity, one cycle per skipped frame.
    send(0, 96'h0);
    @(negedge clk);
    check("t4_tready_back", 32'(tready[0]), 32'd1);
    repeat (NF) @(negedge clk);
    check("t4_busy_skip", 32'(busy[0]), 32'd1);
    @(negedge clk);
    check("t4_busy_clear", 32'(busy[0]), 32'd0);
    wait_idle(0);
    compare_all("t4");

    // Random words on defaults.
    for (int i = 0; i < 4; i++) send(0, rand_word());
    wait_idle(0);
    compare_all("rnd0");

    // Reset while frame 1 is on bit 10 with sclk high.
    rst[0] = 1'b1;
    @(negedge clk);
    #1 rst[0] = 1'b0;
    send(0, {24'h123456, 24'h654321, 24'hFFFFFF, 24'hC0FFEE});
    repeat (282) @(negedge clk);
    check("t5_pre_sync", 32'(sync_n[0]), 32'd0);
    check("t5_pre_sclk", 32'(sclk[0]),   32'd1);
    check("t5_pre_sdo",  32'(sdo[0]),    32'd1);
    #1 rst[0] = 1'b1;
    #1;
    check("t5_rst_sync",   32'(sync_n[0]), 32'd1);
    check("t5_rst_sclk",   32'(sclk[0]),   32'd0);
    check("t5_rst_sdo",    32'(sdo[0]),    32'd0);
    check("t5_rst_tready", 32'(tready[0]), 32'd0);
    check("t5_rst_busy",   32'(busy[0]),   32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst[0] = 1'b0;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge clk);
    check("t5_drop_zero", 32'(drop[0]), 32'd0);
    send(0, rand_word() | 96'h1);
    wait_idle(0);
    compare_all("t5");

    // SKIP_ZERO=0: zero frame sent with full timing.
    send(1, w1);
    for (int i = 0; i < 3; i++) send(1, rand_word());
    wait_idle(1);
    compare_all("t3");

    // SCLK_DIV=1, CS_GAP=1.
    send(2, w1);
    for (int i = 0; i < 6; i++) send(2, rand_word());
    wait_idle(2);
    compare_all("t6");

    check("sdo_only_on_fall", 32'(sdo_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
